// File: rtl/aes_pkg.sv
// Shared AES key-expansion types and helpers: key length and FSM encodings,
// Nk/Nr lookup, S-box and GF(2^8) doubling.
package aes_pkg;

    typedef enum logic [1:0] {
        KeyLen128 = 2'b00,
        KeyLen192 = 2'b01,
        KeyLen256 = 2'b10,
        KeyLenBad = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGen   = 2'b01,
        StDrain = 2'b10
    } state_e;

    // Row-major S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(key_len_e len);
        case (len)
            KeyLen192: return 4'd6;
            KeyLen256: return 4'd8;
            default:   return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_len_e len);
        return nk_of(len) + 4'd6;
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/keyexpansion_stream.sv
// AES-128/192/256 key expansion: one schedule word per cycle from a sliding
// window, packed into 128-bit round keys streamed over valid/ready.
module keyexpansion_stream
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256,
    parameter int unsigned RK_INDEX_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [255:0]          key,
    output logic                  busy,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [127:0]          rk,
    output logic [RK_INDEX_W-1:0] rk_index,
    output logic                  rk_last
);

    state_e                  state_q;
    logic [3:0]              nk_q;
    logic [3:0]              nr_q;
    logic [31:0]             win_q [8];
    logic [31:0]             asm_q [3];
    logic [5:0]              i_q;
    logic [2:0]              imod_q;
    logic [7:0]              rcon_q;
    logic                    busy_q;
    logic                    rk_valid_q;
    logic                    rk_last_q;
    logic [127:0]            rk_q;
    logic [RK_INDEX_W-1:0]   rk_index_q;

    logic [2:0]  last_idx;
    logic [31:0] w_prev;
    logic [31:0] w_old;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] new_word;
    logic        from_key;
    logic        grp_last;
    logic        can_load;
    logic        advance;
    logic        word_last;
    logic        handshake;
    logic        len_ok;

    // Window holds w[i-Nk] in slot 0 and w[i-1] in slot Nk-1 once i >= Nk.
    assign last_idx = 3'(nk_q - 4'd1);
    assign w_prev   = win_q[last_idx];
    assign w_old    = win_q[0];
    assign sub_in   = (imod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        from_key  = i_q < {2'b00, nk_q};
        grp_last  = i_q[1:0] == 2'b11;
        handshake = rk_valid_q && rk_ready;
        can_load  = !rk_valid_q || rk_ready;
        advance   = (state_q == StGen) && (!grp_last || can_load);
        word_last = i_q == {nr_q, 2'b11};
        if (from_key) begin
            new_word = win_q[i_q[2:0]];
        end else if (imod_q == 3'd0) begin
            new_word = w_old ^ sub_out ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && imod_q == 3'd4) begin
            new_word = w_old ^ sub_out;
        end else begin
            new_word = w_old ^ w_prev;
        end
    end

    always_comb begin
        len_ok = 1'b0;
        case (key_len_e'(key_len))
            KeyLen128: len_ok = MAX_KEY_BITS >= 32'd128;
            KeyLen192: len_ok = MAX_KEY_BITS >= 32'd192;
            KeyLen256: len_ok = MAX_KEY_BITS >= 32'd256;
            default:   len_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            nk_q       <= 4'd0;
            nr_q       <= 4'd0;
            for (int j = 0; j < 8; j++) win_q[j] <= 32'h0;
            for (int j = 0; j < 3; j++) asm_q[j] <= 32'h0;
            i_q        <= 6'd0;
            imod_q     <= 3'd0;
            rcon_q     <= 8'h0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_q       <= 128'h0;
            rk_index_q <= '0;
        end else begin
            if (handshake) begin
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (start && len_ok) begin
                        nk_q    <= nk_of(key_len_e'(key_len));
                        nr_q    <= nr_of(key_len_e'(key_len));
                        for (int j = 0; j < 8; j++) win_q[j] <= key[255 - 32 * j -: 32];
                        i_q     <= 6'd0;
                        imod_q  <= 3'd0;
                        rcon_q  <= 8'h01;
                        busy_q  <= 1'b1;
                        state_q <= StGen;
                    end
                end
                StGen: begin
                    if (advance) begin
                        if (!from_key) begin
                            for (int j = 0; j < 7; j++) begin
                                if (3'(j) == last_idx) win_q[j] <= new_word;
                                else                   win_q[j] <= win_q[j + 1];
                            end
                            win_q[7] <= new_word;
                            if (imod_q == 3'd0) rcon_q <= xtime(rcon_q);
                        end
                        if (grp_last) begin
                            rk_q       <= {asm_q[0], asm_q[1], asm_q[2], new_word};
                            rk_valid_q <= 1'b1;
                            rk_index_q <= RK_INDEX_W'(i_q[5:2]);
                            rk_last_q  <= word_last;
                        end else begin
                            for (int j = 0; j < 3; j++) begin
                                if (i_q[1:0] == 2'(j)) asm_q[j] <= new_word;
                            end
                        end
                        imod_q <= (imod_q == last_idx) ? 3'd0 : imod_q + 3'd1;
                        i_q    <= i_q + 6'd1;
                        if (word_last) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (handshake && rk_last_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk       = rk_q;
    assign rk_index = rk_index_q;
    assign rk_last  = rk_last_q;

endmodule
